// File: rtl/uart_frame_host_pkg.sv
// Shared definitions for the host end of the 128-bit UART frame link.
// Frames travel MSB byte first: byte [W-1:W-8] is the first on the line in both directions.
package uart_frame_host_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      SEND      = 2'b01,
      WAIT_RESP = 2'b10,
      DONE      = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'b00,
      RX_START = 2'b01,
      RX_DATA  = 2'b10,
      RX_STOP  = 2'b11
   } rx_state_e;

   localparam int FRAME_W         = 128;
   localparam int DEF_FRAME_BYTES = 16;
   localparam int CNT_W           = 5;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_frame_host_uart.sv
// 8N1 byte UART: one transmit byte per valid/ack, one receive pulse per good stop bit.
// tx_data_ack_o is combinational and fires on the cycle the idle transmitter takes the byte.
module uart_frame_host_uart
   import uart_frame_host_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_data_valid_i,
   output logic       tx_data_ack_o,
   output logic [7:0] rx_data_o,
   output logic       rx_data_fresh_o,
   output logic       txd_o,
   input  logic       rxd_i
);

   localparam int DIV   = clks_per_bit(CLK_HZ, BAUD);
   localparam int DIV_W = $clog2(DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV / 2 - 1);

   logic             tx_busy_q;
   logic [DIV_W-1:0] tx_div_q;
   logic [3:0]       tx_bit_q;
   logic [8:0]       tx_sr_q;
   logic             txd_q;

   rx_state_e        rx_state_q;
   logic             rxd_s1_q, rxd_s2_q;
   logic [DIV_W-1:0] rx_div_q;
   logic [2:0]       rx_bit_q;
   logic [7:0]       rx_sr_q;
   logic [7:0]       rx_data_q;
   logic             rx_fresh_q;

   assign tx_data_ack_o   = tx_data_valid_i & ~tx_busy_q;
   assign txd_o           = txd_q;
   assign rx_data_o       = rx_data_q;
   assign rx_data_fresh_o = rx_fresh_q;

   // tx_sr_q holds {stop, data}; the start bit is driven directly on accept.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_busy_q <= 1'b0;
         tx_div_q  <= '0;
         tx_bit_q  <= '0;
         tx_sr_q   <= '1;
         txd_q     <= 1'b1;
      end else if (!tx_busy_q) begin
         if (tx_data_valid_i) begin
            tx_busy_q <= 1'b1;
            tx_sr_q   <= {1'b1, tx_data_i};
            txd_q     <= 1'b0;
            tx_div_q  <= '0;
            tx_bit_q  <= '0;
         end
      end else if (tx_div_q == DIV_LAST) begin
         tx_div_q <= '0;
         if (tx_bit_q == 4'd9) begin
            tx_busy_q <= 1'b0;
            txd_q     <= 1'b1;
         end else begin
            tx_bit_q <= tx_bit_q + 4'd1;
            txd_q    <= tx_sr_q[0];
            tx_sr_q  <= {1'b1, tx_sr_q[8:1]};
         end
      end else begin
         tx_div_q <= tx_div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_state_q <= RX_IDLE;
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rx_div_q   <= '0;
         rx_bit_q   <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_fresh_q <= 1'b0;
      end else begin
         rxd_s1_q   <= rxd_i;
         rxd_s2_q   <= rxd_s1_q;
         rx_fresh_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               rx_div_q <= '0;
               if (!rxd_s2_q) rx_state_q <= RX_START;
            end
            RX_START: begin
               // Re-check the start bit at mid-bit to reject glitches.
               if (rx_div_q == HALF_LAST) begin
                  rx_div_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_div_q <= rx_div_q + DIV_W'(1);
               end
            end
            RX_DATA: begin
               if (rx_div_q == DIV_LAST) begin
                  rx_div_q <= '0;
                  rx_sr_q  <= {rxd_s2_q, rx_sr_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                  else                  rx_bit_q   <= rx_bit_q + 3'd1;
               end else begin
                  rx_div_q <= rx_div_q + DIV_W'(1);
               end
            end
            RX_STOP: begin
               if (rx_div_q == DIV_LAST) begin
                  rx_div_q   <= '0;
                  rx_data_q  <= rx_sr_q;
                  rx_fresh_q <= rxd_s2_q;
                  rx_state_q <= RX_IDLE;
               end else begin
                  rx_div_q <= rx_div_q + DIV_W'(1);
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_frame_host.sv
// Host end of the UART frame link: serialises one request frame MSB byte first,
// then gathers the response frame, reporting a left-aligned partial frame on timeout.
module uart_frame_host
   import uart_frame_host_pkg::*;
#(
   parameter int CLK_HZ         = 100_000_000,
   parameter int BAUD           = 115200,
   parameter int FRAME_BYTES    = DEF_FRAME_BYTES,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [FRAME_BYTES*8-1:0] req_data,
   output logic                     resp_valid,
   output logic [FRAME_BYTES*8-1:0] resp_data,
   output logic                     resp_timeout,
   output logic                     busy,
   output logic                     uart_txd,
   input  logic                     uart_rxd,
   output logic [1:0]               dbg_state
);

   localparam int FW    = FRAME_BYTES * 8;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q;
   logic [FW-1:0]    tx_shift_q;
   logic [CNT_W-1:0] tx_cnt_q;
   logic             tx_valid_q;
   logic [FW-1:0]    rx_shift_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [TMO_W-1:0] tmo_q;
   logic             req_ready_q;
   logic             busy_q;
   logic             resp_valid_q;
   logic [FW-1:0]    resp_data_q;
   logic             resp_timeout_q;

   logic [FW-1:0]    rx_shift_d;
   logic [FW-1:0]    partial_d;
   logic             tx_ack;
   logic [7:0]       rx_data;
   logic             rx_fresh;

   assign rx_shift_d = {rx_shift_q[FW-9:0], rx_data};
   // Received bytes sit in the low end of rx_shift_q; move them up to the frame MSB.
   assign partial_d  = rx_shift_q << (8 * (FRAME_BYTES - int'(rx_cnt_q)));

   assign req_ready    = req_ready_q;
   assign busy         = busy_q;
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_timeout = resp_timeout_q;
   assign dbg_state    = state_q;

   uart_frame_host_uart #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_uart (
      .clk_i           (clk),
      .rst_i           (rst),
      .tx_data_i       (tx_shift_q[FW-1 -: 8]),
      .tx_data_valid_i (tx_valid_q),
      .tx_data_ack_o   (tx_ack),
      .rx_data_o       (rx_data),
      .rx_data_fresh_o (rx_fresh),
      .txd_o           (uart_txd),
      .rxd_i           (uart_rxd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         tx_shift_q     <= '0;
         tx_cnt_q       <= '0;
         tx_valid_q     <= 1'b0;
         rx_shift_q     <= '0;
         rx_cnt_q       <= '0;
         tmo_q          <= '0;
         req_ready_q    <= 1'b1;
         busy_q         <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_data_q    <= '0;
         resp_timeout_q <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  tx_shift_q  <= req_data;
                  tx_cnt_q    <= '0;
                  tx_valid_q  <= 1'b0;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= SEND;
               end
            end
            SEND: begin
               // valid drops on the ack cycle and comes back no sooner than the next one.
               if (tx_valid_q && tx_ack) begin
                  tx_valid_q <= 1'b0;
                  tx_shift_q <= tx_shift_q << 8;
                  tx_cnt_q   <= tx_cnt_q + CNT_W'(1);
                  if (tx_cnt_q == LAST_BYTE) begin
                     rx_cnt_q   <= '0;
                     tmo_q      <= '0;
                     rx_shift_q <= '0;
                     state_q    <= WAIT_RESP;
                  end
               end else if (!tx_valid_q) begin
                  tx_valid_q <= 1'b1;
               end
            end
            WAIT_RESP: begin
               // A byte arriving on the terminal-count cycle takes priority over the timeout.
               if (rx_fresh) begin
                  rx_shift_q <= rx_shift_d;
                  rx_cnt_q   <= rx_cnt_q + CNT_W'(1);
                  tmo_q      <= '0;
                  if (rx_cnt_q == LAST_BYTE) begin
                     resp_valid_q   <= 1'b1;
                     resp_data_q    <= rx_shift_d;
                     resp_timeout_q <= 1'b0;
                     state_q        <= DONE;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  resp_valid_q   <= 1'b1;
                  resp_data_q    <= partial_d;
                  resp_timeout_q <= 1'b1;
                  state_q        <= DONE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            DONE: begin
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_host.sv
// Bench for uart_frame_host: line-level BFM peer, tx/resp scoreboards with expected queues.
`timescale 1ns/1ps
module tb_uart_frame_host;

   localparam int CLK_HZ  = 1_000_000;
   localparam int BAUD    = 100_000;
   localparam int BIT_CLK = CLK_HZ / BAUD;
   localparam int TMO     = 5000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [127:0] req_data = '0;
   logic         resp_valid;
   logic [127:0] resp_data;
   logic         resp_timeout;
   logic         busy;
   logic         uart_txd;
   logic         uart_rxd = 1'b1;
   logic [1:0]   dbg_state;

   int n_compared   = 0;
   int n_mismatched = 0;
   int tx_seen      = 0;
   int resp_seen    = 0;

   logic [7:0]   exp_tx_q[$];
   logic [128:0] exp_resp_q[$];

   uart_frame_host #(
      .CLK_HZ         (CLK_HZ),
      .BAUD           (BAUD),
      .FRAME_BYTES    (16),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_data     (req_data),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_timeout (resp_timeout),
      .busy         (busy),
      .uart_txd     (uart_txd),
      .uart_rxd     (uart_rxd),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_request(input logic [127:0] d);
      for (int i = 0; i < 16; i++) exp_tx_q.push_back(d[127-8*i -: 8]);
      tx_seen = 0;
      check("req_ready_before_req", {127'd0, req_ready}, 128'd1);
      req_data  = d;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int budget);
      int c;
      c = 0;
      while (tx_seen < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("tx_byte_count", 128'(tx_seen), 128'(n));
   endtask

   task automatic wait_resp(input int target, input int budget);
      int c;
      c = 0;
      while (resp_seen < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("resp_count", 128'(resp_seen), 128'(target));
   endtask

   task automatic peer_byte(input logic [7:0] b);
      uart_rxd = 1'b0;
      tick(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         tick(BIT_CLK);
      end
      uart_rxd = 1'b1;
      tick(BIT_CLK + 2);
   endtask

   task automatic peer_seq(input logic [7:0] base);
      for (int i = 0; i < 16; i++) peer_byte(base + 8'(i));
   endtask

   // Line decoder for the DUT transmitter; a byte cut by reset is abandoned.
   initial begin : tx_monitor
      logic [7:0] b;
      logic       sb;
      logic       ab;
      forever begin
         @(negedge clk);
         if (!rst && uart_txd === 1'b0) begin
            ab = 1'b0;
            for (int k = 0; k < BIT_CLK / 2; k++) begin @(negedge clk); ab = ab | rst; end
            for (int i = 0; i < 8; i++) begin
               for (int k = 0; k < BIT_CLK; k++) begin @(negedge clk); ab = ab | rst; end
               b[i] = uart_txd;
            end
            for (int k = 0; k < BIT_CLK; k++) begin @(negedge clk); ab = ab | rst; end
            sb = uart_txd;
            if (!ab) begin
               tx_seen++;
               if (exp_tx_q.size() == 0) begin
                  n_compared++;
                  n_mismatched++;
                  $display("FAIL tx_extra: got byte %h expected none", b);
               end else begin
                  check("tx_byte", {120'd0, b}, {120'd0, exp_tx_q.pop_front()});
                  check("tx_stop", {127'd0, sb}, 128'd1);
               end
            end
         end
      end
   end

   initial begin : resp_monitor
      logic         prev_resp;
      logic [128:0] e;
      prev_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_resp) begin
            check("resp_valid_pulse", {127'd0, resp_valid}, 128'd0);
            check("busy_after_done", {127'd0, busy}, 128'd0);
            check("ready_after_done", {127'd0, req_ready}, 128'd1);
         end
         prev_resp = resp_valid;
         if (resp_valid === 1'b1) begin
            resp_seen++;
            if (exp_resp_q.size() == 0) begin
               n_compared++;
               n_mismatched++;
               $display("FAIL spurious_resp: got data %h expected no response", resp_data);
            end else begin
               e = exp_resp_q.pop_front();
               check("resp_data", resp_data, e[127:0]);
               check("resp_timeout", {127'd0, resp_timeout}, {127'd0, e[128]});
            end
         end
      end
   end

   initial begin : main
      // Reset values
      tick(3);
      check("rst_req_ready", {127'd0, req_ready}, 128'd1);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
      check("rst_resp_data", resp_data, 128'd0);
      check("rst_resp_timeout", {127'd0, resp_timeout}, 128'd0);
      check("rst_txd", {127'd0, uart_txd}, 128'd1);
      check("rst_state", {126'd0, dbg_state}, 128'd0);
      rst = 1'b0;
      tick(5);

      // Full request then full response
      send_request(128'h000102030405060708090A0B0C0D0E0F);
      wait_tx(1, 400);
      check("send_req_ready", {127'd0, req_ready}, 128'd0);
      check("send_busy", {127'd0, busy}, 128'd1);
      check("send_state", {126'd0, dbg_state}, 128'd1);
      wait_tx(16, 2000);
      check("wait_state", {126'd0, dbg_state}, 128'd2);
      check("wait_req_ready", {127'd0, req_ready}, 128'd0);
      exp_resp_q.push_back({1'b0, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF});
      peer_seq(8'hF0);
      wait_resp(1, 500);
      tick(20);

      // Partial response then timeout
      send_request(128'h11111111222222223333333344444444);
      wait_tx(16, 2000);
      exp_resp_q.push_back({1'b1, 128'hAABBCC00000000000000000000000000});
      peer_byte(8'hAA);
      peer_byte(8'hBB);
      peer_byte(8'hCC);
      wait_resp(2, TMO + 1000);
      tick(20);

      // Second request while sending is neither taken nor queued
      send_request(128'hDEADBEEF0123456789ABCDEFCAFEF00D);
      tick(3);
      req_data  = '1;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      wait_tx(16, 2000);
      exp_resp_q.push_back({1'b0, 128'h303132333435363738393A3B3C3D3E3F});
      peer_seq(8'h30);
      wait_resp(3, 500);
      tick(300);
      check("ignored_req_tx_count", 128'(tx_seen), 128'd16);
      check("ignored_req_idle", {126'd0, dbg_state}, 128'd0);

      // Reset in the middle of the 7th byte
      send_request(128'h00112233445566778899AABBCCDDEEFF);
      wait_tx(6, 1000);
      tick(20);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_txd", {127'd0, uart_txd}, 128'd1);
      check("midrst_req_ready", {127'd0, req_ready}, 128'd1);
      check("midrst_resp_valid", {127'd0, resp_valid}, 128'd0);
      check("midrst_busy", {127'd0, busy}, 128'd0);
      tick(2);
      rst = 1'b0;
      exp_tx_q.delete();
      tick(200);
      check("post_rst_txd", {127'd0, uart_txd}, 128'd1);
      send_request(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      wait_tx(16, 2000);
      exp_resp_q.push_back({1'b0, 128'h505152535455565758595A5B5C5D5E5F});
      peer_seq(8'h50);
      wait_resp(4, 500);
      tick(20);

      // Stray bytes while idle are dropped
      peer_byte(8'h11);
      peer_byte(8'h22);
      peer_byte(8'h33);
      tick(50);
      check("stray_idle_state", {126'd0, dbg_state}, 128'd0);
      send_request(128'h0F0E0D0C0B0A09080706050403020100);
      wait_tx(16, 2000);
      exp_resp_q.push_back({1'b0, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF});
      peer_seq(8'hC0);
      wait_resp(5, 500);
      tick(50);

      check("tx_queue_drained", 128'(exp_tx_q.size()), 128'd0);
      check("resp_queue_drained", 128'(exp_resp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
